// File: rtl/qam_hard_slicer_if.sv
// Sample input and FIFO write port of the QAM hard slicer.
// The slicer side (master) consumes demod samples and FIFO status and
// produces FIFO writes; the environment side (slave) is the mirror image.
interface qam_hard_slicer_if #(
  parameter int IQ_W     = 8,
  parameter int MOD_BITS = 4
);
  logic signed [IQ_W-1:0] i_in;
  logic signed [IQ_W-1:0] q_in;
  logic                   in_valid;
  logic                   wfull;
  logic [MOD_BITS-1:0]    sym_out;
  logic                   wrreq;

  modport master (
    input  i_in, q_in, in_valid, wfull,
    output sym_out, wrreq
  );

  modport slave (
    output i_in, q_in, in_valid, wfull,
    input  sym_out, wrreq
  );
endinterface

// File: rtl/qam_hard_slicer.sv
// QAM hard-decision slicer with preamble hunt and fixed-length frame
// forwarding. Two pipeline stages (capture, decide) feed a HUNT/PASS
// controller whose registered write request drives the FIFO write port.
module qam_hard_slicer #(
  parameter int         IQ_W      = 8,
  parameter int         MOD_BITS  = 4,
  parameter int         SCALE     = 32,
  parameter logic [3:0] PRE_SYM   = 4'b1010,
  parameter int         PRE_LEN   = 4,
  parameter int         FRAME_LEN = 64,
  parameter int         DROP_W    = 8
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              enable,
  qam_hard_slicer_if.master bus,
  output logic              locked,
  output logic              frame_done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int MATCH_W = $clog2(PRE_LEN + 1);
  localparam int PAY_W   = $clog2(FRAME_LEN + 1);

  localparam logic [MOD_BITS-1:0] PRE_DEC    = PRE_SYM[MOD_BITS-1:0];
  localparam logic [IQ_W:0]       INNER_THR  = (IQ_W + 1)'(2 * SCALE);
  localparam logic [MATCH_W-1:0]  MATCH_LAST = MATCH_W'(PRE_LEN - 1);
  localparam logic [PAY_W-1:0]    PAY_LAST   = PAY_W'(FRAME_LEN - 1);

  typedef enum logic {
    HUNT = 1'b0,
    PASS = 1'b1
  } state_e;

  // Per-axis hard decision: {sign, inner}. Magnitude is taken one bit wider
  // than the sample so the most negative input does not wrap to itself.
  function automatic logic [1:0] axis_bits(input logic signed [IQ_W-1:0] x);
    logic signed [IQ_W:0] x_ext;
    logic [IQ_W:0]        mag;
    x_ext = {x[IQ_W-1], x};
    mag   = x_ext[IQ_W] ? $unsigned(-x_ext) : $unsigned(x_ext);
    return {~x[IQ_W-1], (mag < INNER_THR)};
  endfunction

  // Stage 1 (raw sample) and stage 2 (decision) registers.
  logic signed [IQ_W-1:0] i1_q, q1_q;
  logic                   v1_q;
  logic [MOD_BITS-1:0]    dec2_q;
  logic                   v2_q;

  // Controller state.
  state_e                 state_q, state_d;
  logic [MATCH_W-1:0]     match_q, match_d;
  logic [PAY_W-1:0]       pay_q, pay_d;
  logic                   wrreq_q, wrreq_d;
  logic [MOD_BITS-1:0]    sym_q, sym_d;
  logic                   done_q, done_d;
  logic [DROP_W-1:0]      drop_q, drop_d;

  // Combinational decision from the stage-1 sample.
  logic [1:0]             i_bits, q_bits;
  logic [MOD_BITS-1:0]    dec;

  assign i_bits = axis_bits(i1_q);
  assign q_bits = axis_bits(q1_q);

  // Gray per axis falls out of {sign, inner}: -3->00, -1->01, +1->11, +3->10.
  if (MOD_BITS == 4) begin : g_qam16
    assign dec = {i_bits, q_bits};
  end else begin : g_qpsk
    assign dec = {i_bits[1], q_bits[1]};
  end

  // Two-stage sample pipeline; it keeps running regardless of enable.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      i1_q   <= '0;
      q1_q   <= '0;
      v1_q   <= 1'b0;
      dec2_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      i1_q   <= bus.i_in;
      q1_q   <= bus.q_in;
      v1_q   <= bus.in_valid;
      dec2_q <= dec;
      v2_q   <= v1_q;
    end
  end

  // Controller state and registered FIFO-side outputs.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      match_q <= '0;
      pay_q   <= '0;
      wrreq_q <= 1'b0;
      sym_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      pay_q   <= pay_d;
      wrreq_q <= wrreq_d;
      sym_q   <= sym_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic: preamble hunt, payload forwarding, drop accounting.
  // NOTE: every output of this block gets a default before any branch so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    pay_d   = pay_q;
    wrreq_d = 1'b0;
    sym_d   = sym_q;
    done_d  = 1'b0;
    drop_d  = drop_q;

    if (!enable) begin
      // Disabled: abandon any frame in progress; drop count is kept.
      state_d = HUNT;
      match_d = '0;
      pay_d   = '0;
    end else if (v2_q) begin
      unique case (state_q)
        HUNT: begin
          if (dec2_q == PRE_DEC) begin
            if (match_q == MATCH_LAST) begin
              state_d = PASS;
              match_d = '0;
              pay_d   = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        PASS: begin
          pay_d = pay_q + PAY_W'(1);
          if (!bus.wfull) begin
            wrreq_d = 1'b1;
            sym_d   = dec2_q;
          end else if (drop_q != '1) begin
            drop_d = drop_q + DROP_W'(1);
          end
          // The last payload symbol ends the frame whether written or dropped.
          if (pay_q == PAY_LAST) begin
            state_d = HUNT;
            done_d  = 1'b1;
            match_d = '0;
            pay_d   = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Write request is cut off in the very cycle enable falls.
  assign bus.wrreq   = wrreq_q & enable;
  assign bus.sym_out = sym_q;
  assign locked      = (state_q == PASS);
  assign frame_done  = done_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_qam_hard_slicer.sv
// Self-checking bench for qam_hard_slicer. A behavioural model derives the
// expected FIFO writes, lock state, frame pulses and drop counts from the
// applied samples; literal checks pin the model on directed scenarios.
// A second instance with a 4-bit drop counter shares the stimulus.
module tb_qam_hard_slicer;

  localparam int         IQ_W      = 8;
  localparam int         MOD_BITS  = 4;
  localparam int         SCALE     = 32;
  localparam logic [3:0] PRE_SYM   = 4'b1010;
  localparam int         PRE_LEN   = 4;
  localparam int         FRAME_LEN = 64;
  localparam int         DROP_MAX8 = 255;
  localparam int         DROP_MAX4 = 15;

  logic       sclk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       locked, frame_done, locked4, frame_done4;
  logic [7:0] drop_cnt;
  logic [3:0] drop_cnt4;

  int n_checks = 0;
  int n_err    = 0;

  qam_hard_slicer_if #(.IQ_W(IQ_W), .MOD_BITS(MOD_BITS)) bus  ();
  qam_hard_slicer_if #(.IQ_W(IQ_W), .MOD_BITS(MOD_BITS)) bus4 ();

  assign bus4.i_in     = bus.i_in;
  assign bus4.q_in     = bus.q_in;
  assign bus4.in_valid = bus.in_valid;
  assign bus4.wfull    = bus.wfull;

  qam_hard_slicer #(.DROP_W(8)) dut (
    .sclk       (sclk),
    .reset      (rst_n),
    .enable     (enable),
    .bus        (bus.master),
    .locked     (locked),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  qam_hard_slicer #(.DROP_W(4)) dut4 (
    .sclk       (sclk),
    .reset      (rst_n),
    .enable     (enable),
    .bus        (bus4.master),
    .locked     (locked4),
    .frame_done (frame_done4),
    .drop_cnt   (drop_cnt4)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Nearest constellation level per axis (units of SCALE), then its Gray code.
  function automatic logic [1:0] axis_gray(input int x);
    int lvl;
    if (x >= 0) lvl = (x >= 2 * SCALE) ? 3 : 1;
    else        lvl = (x <= -2 * SCALE) ? -3 : -1;
    case (lvl)
      -3:      return 2'b00;
      -1:      return 2'b01;
      1:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [3:0] slice16(input int i, input int q);
    return {axis_gray(i), axis_gray(q)};
  endfunction

  // ---------------- behavioural model ----------------
  logic [3:0] m_dly_sym [2];
  bit         m_dly_v   [2];
  int         m_matches = 0, m_payload = 0, m_drops8 = 0, m_drops4 = 0;
  bit         m_locked = 0, m_wr = 0, m_done = 0;
  logic [3:0] m_sym = '0;

  // A sample's decision is acted on two edges after it is captured; the
  // resulting write/lock/done is visible after that edge.
  initial begin
    m_dly_v[0] = 0; m_dly_v[1] = 0; m_dly_sym[0] = '0; m_dly_sym[1] = '0;
    forever begin
      bit         pv;
      logic [3:0] ps;
      @(posedge sclk or negedge rst_n);
      if (!rst_n) begin
        m_dly_v[0] = 0; m_dly_v[1] = 0; m_dly_sym[0] = '0; m_dly_sym[1] = '0;
        m_matches = 0; m_payload = 0; m_drops8 = 0; m_drops4 = 0;
        m_locked = 0; m_wr = 0; m_done = 0; m_sym = '0;
      end else begin
        pv = m_dly_v[1];
        ps = m_dly_sym[1];
        m_dly_v[1]   = m_dly_v[0];
        m_dly_sym[1] = m_dly_sym[0];
        m_dly_v[0]   = bus.in_valid;
        m_dly_sym[0] = slice16(bus.i_in, bus.q_in);
        m_wr   = 0;
        m_done = 0;
        if (!enable) begin
          m_locked = 0; m_matches = 0; m_payload = 0;
        end else if (pv) begin
          if (!m_locked) begin
            m_matches = (ps == PRE_SYM) ? m_matches + 1 : 0;
            if (m_matches == PRE_LEN) begin
              m_locked = 1; m_matches = 0; m_payload = 0;
            end
          end else begin
            m_payload++;
            if (!bus.wfull) begin
              m_wr  = 1;
              m_sym = ps;
            end else begin
              if (m_drops8 < DROP_MAX8) m_drops8++;
              if (m_drops4 < DROP_MAX4) m_drops4++;
            end
            if (m_payload == FRAME_LEN) begin
              m_done = 1; m_locked = 0; m_matches = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int         n_wr = 0, n_done = 0;
  logic [3:0] got [$];

  initial begin
    forever begin
      @(negedge sclk);
      check("wrreq",       bus.wrreq,   m_wr & enable);
      check("locked",      locked,      m_locked);
      check("frame_done",  frame_done,  m_done);
      check("drop_cnt",    drop_cnt,    m_drops8);
      check("wrreq4",      bus4.wrreq,  m_wr & enable);
      check("locked4",     locked4,     m_locked);
      check("frame_done4", frame_done4, m_done);
      check("drop_cnt4",   drop_cnt4,   m_drops4);
      if (bus.wrreq) begin
        check("sym_out", bus.sym_out, m_sym);
        got.push_back(bus.sym_out);
        n_wr++;
      end
      if (bus4.wrreq) check("sym_out4", bus4.sym_out, m_sym);
      if (frame_done) n_done++;
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle of inputs; they are captured at the next rising edge.
  task automatic step(input bit v, input int i, input int q, input bit wf);
    bus.in_valid = v;
    bus.i_in     = IQ_W'(i);
    bus.q_in     = IQ_W'(q);
    bus.wfull    = wf;
    @(posedge sclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic preamble();
    for (int k = 0; k < PRE_LEN; k++) step(1, 3 * SCALE, 3 * SCALE, 0);
  endtask

  function automatic int lvl(input int k);
    case (k % 4)
      0:       return -3 * SCALE;
      1:       return -SCALE;
      2:       return SCALE;
      default: return 3 * SCALE;
    endcase
  endfunction

  // Contiguous payload over all 16 points; wfull is high on steps [wf_from, wf_to).
  task automatic payload(input int n, input int wf_from, input int wf_to);
    for (int k = 0; k < n; k++)
      step(1, lvl(k), lvl(k / 4), (k >= wf_from) && (k < wf_to));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr_base, done_base;
    rst_n = 1'b0;
    enable = 1'b1;
    bus.in_valid = 1'b0; bus.i_in = '0; bus.q_in = '0; bus.wfull = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    check("rst_wrreq",      bus.wrreq,   0);
    check("rst_locked",     locked,      0);
    check("rst_frame_done", frame_done,  0);
    check("rst_drop_cnt",   drop_cnt,    0);
    check("rst_sym_out",    bus.sym_out, 0);
    @(negedge sclk);
    rst_n = 1'b1;
    @(posedge sclk);
    #1;

    // A: lock and forward a clean frame; first four payloads are slicing vectors.
    wr_base = n_wr; done_base = n_done;
    preamble();
    step(1, 96, -32, 0);
    check("a_locked_early", locked, 0);
    step(1, -96, 32, 0);
    check("a_locked_rise", locked, 1);
    check("a_no_wr_yet", bus.wrreq, 0);
    step(1, 0, -1, 0);
    check("a_first_wr", bus.wrreq, 1);
    check("a_first_sym", bus.sym_out, 4'b1001);
    step(1, -128, 127, 0);
    payload(FRAME_LEN - 4, 0, 0);
    idle(4);
    check("a_wr_count", n_wr - wr_base, 64);
    check("a_done_count", n_done - done_base, 1);
    check("a_back_hunt", locked, 0);
    check("a_sym0", got[wr_base],     4'b1001);
    check("a_sym1", got[wr_base + 1], 4'b0011);
    check("a_sym2", got[wr_base + 2], 4'b1101);
    check("a_sym3", got[wr_base + 3], 4'b0010);

    // B: broken preamble must not lock; C: same frame with 10 drops.
    wr_base = n_wr; done_base = n_done;
    step(1, 96, 96, 0); step(1, 96, 96, 0); step(1, 96, 96, 0);
    step(1, -32, -32, 0);
    step(1, 96, 96, 0); step(1, 96, 96, 0); step(1, 96, 96, 0);
    check("b_not_locked", locked, 0);
    step(1, 96, 96, 0);
    check("b_no_wr_before_lock", n_wr - wr_base, 0);
    payload(FRAME_LEN, 20, 30);
    idle(4);
    check("c_wr_count", n_wr - wr_base, 54);
    check("c_drop_cnt", drop_cnt, 10);
    check("c_drop_cnt4", drop_cnt4, 10);
    check("c_done_count", n_done - done_base, 1);

    // D: 20 drops in the body plus the last symbol dropped; 4-bit count saturates.
    wr_base = n_wr; done_base = n_done;
    preamble();
    payload(FRAME_LEN, 10, 30);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(3);
    check("d_wr_count", n_wr - wr_base, 43);
    check("d_drop_cnt", drop_cnt, 31);
    check("d_drop_sat4", drop_cnt4, 15);
    check("d_done_count", n_done - done_base, 1);
    check("d_back_hunt", locked, 0);

    // E: enable falls after payload 30; samples 0..26 reach the FIFO before it.
    wr_base = n_wr; done_base = n_done;
    preamble();
    payload(30, 0, 0);
    check("e_wrreq_before", bus.wrreq, 1);
    enable = 1'b0;
    #1;
    check("e_wrreq_gated", bus.wrreq, 0);
    for (int k = 30; k < 34; k++) step(1, lvl(k), lvl(k / 4), 0);
    check("e_unlocked", locked, 0);
    enable = 1'b1;
    payload(30, 0, 0);
    idle(4);
    check("e_wr_count", n_wr - wr_base, 27);
    check("e_no_done", n_done - done_base, 0);
    check("e_still_hunt", locked, 0);

    // F: async reset mid-frame, off the clock edge, then a clean relock.
    preamble();
    payload(20, 0, 0);
    check("f_locked_before", locked, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("f_rst_wrreq",    bus.wrreq,  0);
    check("f_rst_locked",   locked,     0);
    check("f_rst_done",     frame_done, 0);
    check("f_rst_drop_cnt", drop_cnt,   0);
    check("f_rst_drop4",    drop_cnt4,  0);
    check("f_rst_sym_out",  bus.sym_out, 0);
    @(posedge sclk);
    #1;
    idle(1);
    #3;
    rst_n = 1'b1;
    @(posedge sclk);
    #1;
    idle(2);
    wr_base = n_wr; done_base = n_done;
    preamble();
    payload(FRAME_LEN, 0, 0);
    idle(4);
    check("f_wr_count", n_wr - wr_base, 64);
    check("f_done_count", n_done - done_base, 1);
    check("f_drop_cnt", drop_cnt, 0);
    check("f_back_hunt", locked, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
